// File: rtl/stream_pattern_gen.sv
// -----------------------------------------------------------------------------
// stream_pattern_gen
//
// Stimulus source and sink for the systolic-array / img2col datapath.
// The source replays a preloaded word memory onto a valid/ready master port.
// Its valid duty cycle, beat count, wrap length and last flag are programmable.
// The sink accepts beats with a programmable ready duty cycle and counts them.
//
// Optional build macro: STREAM_GEN_LFSR_EN
//   undefined : valid/ready gates come from a periodic phase counter
//   defined   : valid/ready gates come from a 16-bit Fibonacci LFSR
//               (taps 16,14,13,11, seed 16'hACE1); cfg_period is unused
//
// Ports:
//   clk, reset               clock (rising edge), async active-low reset
//   wr_en/wr_addr/wr_data    replay-memory write port (synchronous)
//   cfg_start                start pulse, honoured only in IDLE
//   cfg_total                beats to emit
//   cfg_len                  replay wrap length (0 = MEM_DEPTH)
//   cfg_period               shaping period (0 behaves as 1)
//   cfg_von / cfg_ron        valid-on / ready-on cycles per period
//   m_valid/m_ready/m_data/m_last   source stream
//   s_valid/s_data/s_ready          sink stream
//   s_cnt                    sink beats accepted since the last start
//   busy                     source is in RUN or DRAIN
//   done                     one-cycle pulse when the source completes
// -----------------------------------------------------------------------------
module stream_pattern_gen #(
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = 50176,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 32,
    parameter int PER_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_total,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [PER_W-1:0]  cfg_von,
    input  logic [PER_W-1:0]  cfg_ron,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [CNT_W-1:0]  s_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Replay memory
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // Control state and latched configuration
    state_t            r_state;
    logic [CNT_W-1:0]  r_total;
    logic [PER_W-1:0]  r_von;
    logic [PER_W-1:0]  r_ron;
    logic [ADDR_W-1:0] r_wrap;      // last read address before wrapping to 0
    logic [CNT_W-1:0]  r_issued;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [CNT_W-1:0]  r_s_cnt;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_last;

    logic              w_start;
    logic              w_busy;
    logic              w_vgate;
    logic              w_rgate;
    logic              w_s_ready;
    logic              w_load;
    logic              w_hs;
    logic              w_last_beat;
    logic [ADDR_W:0]   w_len_eff;
    logic              w_unused;

    assign w_start     = (r_state == ST_IDLE) && cfg_start;
    assign w_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_hs        = r_m_valid && m_ready;
    assign w_last_beat = (r_issued == r_total - CNT_W'(1));
    assign w_load      = (!r_m_valid || m_ready) && (r_state == ST_RUN) &&
                         w_vgate && (r_issued < r_total);
    assign w_s_ready   = w_busy && w_rgate;

    // A zero or oversized wrap length replays the whole memory.
    assign w_len_eff = ((cfg_len == '0) || ({1'b0, cfg_len} > DEPTH_L)) ?
                       DEPTH_L : {1'b0, cfg_len};

    // NOTE: the replay memory has no reset; it is a plain RAM that keeps its
    // preloaded contents across resets and maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

`ifdef STREAM_GEN_LFSR_EN
    // Pseudo-random gating: LFSR reseeds on start and steps every busy cycle.
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_start) begin
            r_lfsr <= 16'hACE1;
        end else if (w_busy) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_vgate  = r_lfsr[7:0]  < r_von[7:0];
    assign w_rgate  = r_lfsr[15:8] < r_ron[7:0];
    assign w_unused = ^{s_data, cfg_period, r_von[PER_W-1:8], r_ron[PER_W-1:8]};
`else
    // Periodic gating: phase runs 0..period-1 while busy. An on-time at or
    // above the period keeps the gate permanently open since phase < period.
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_phase;
    logic [PER_W-1:0] w_per_m1;

    assign w_per_m1 = (r_period == '0) ? '0 : r_period - PER_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
            r_phase  <= '0;
        end else if (w_start) begin
            r_period <= cfg_period;
            r_phase  <= '0;
        end else if (w_busy) begin
            r_phase <= (r_phase >= w_per_m1) ? '0 : r_phase + PER_W'(1);
        end
    end

    assign w_vgate  = r_phase < r_von;
    assign w_rgate  = r_phase < r_ron;
    assign w_unused = ^s_data;
`endif

    // NOTE: every state register uses non-blocking assignment so all of them
    // update together from the values present before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_total   <= '0;
            r_von     <= '0;
            r_ron     <= '0;
            r_wrap    <= '0;
            r_issued  <= '0;
            r_rd_addr <= '0;
            r_s_cnt   <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            // Sink beat counter; the start clear below takes priority.
            if (s_valid && w_s_ready && (r_s_cnt != CNT_MAX)) begin
                r_s_cnt <= r_s_cnt + CNT_W'(1);
            end

            // Source output register: payload holds until its handshake.
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_mem[r_rd_addr];
                r_m_last  <= w_last_beat;
                if (r_issued != CNT_MAX) begin
                    r_issued <= r_issued + CNT_W'(1);
                end
                r_rd_addr <= (r_rd_addr == r_wrap) ? '0 : r_rd_addr + ADDR_W'(1);
            end else if (w_hs) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_total   <= cfg_total;
                        r_von     <= cfg_von;
                        r_ron     <= cfg_ron;
                        r_wrap    <= ADDR_W'(w_len_eff - (ADDR_W + 1)'(1));
                        r_issued  <= '0;
                        r_s_cnt   <= '0;
                        r_rd_addr <= '0;
                        r_state   <= (cfg_total == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_load && w_last_beat) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_hs && r_m_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign s_ready = w_s_ready;
    assign s_cnt   = r_s_cnt;
    assign busy    = w_busy;
    assign done    = (r_state == ST_DONE);

endmodule
